// File: rtl/ramio_arbiter_pkg.sv
// Shared encodings for the RAMIO arbiter: transfer sizes, read-type
// layout, arbiter states and command classification.
package ramio_arbiter_pkg;

    typedef enum logic [1:0] {
        WT_NONE = 2'b00,
        WT_BYTE = 2'b01,
        WT_HALF = 2'b10,
        WT_WORD = 2'b11
    } size_e;

    localparam int         RT_SEXT_BIT = 2;
    localparam logic [2:0] RT_NONE     = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        K_NOP = 2'b00,
        K_WR  = 2'b01,
        K_RD  = 2'b10
    } kind_e;

    // A write type wins over any read type on the same command.
    function automatic kind_e cmd_kind(
        input logic [1:0] wt,
        input logic [2:0] rt
    );
        logic [1:0] rsz;
        rsz = rt[RT_SEXT_BIT-1:0];
        if (wt != WT_NONE) begin
            return K_WR;
        end
        if (rt[RT_SEXT_BIT] || (rsz != WT_NONE)) begin
            return K_RD;
        end
        return K_NOP;
    endfunction

endpackage

// File: rtl/ramio_arbiter_if.sv
// Bundle of both request ports plus the shared RAMIO command bus.
// slave: the arbiter side; master: requesters and RAMIO model.
interface ramio_arbiter_if #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32
);
    logic                        p0_req;
    logic [1:0]                  p0_write_type;
    logic [2:0]                  p0_read_type;
    logic [ADDRESS_BITWIDTH-1:0] p0_address;
    logic [DATA_WIDTH-1:0]       p0_data_in;
    logic                        p0_gnt;
    logic                        p0_done;
    logic [DATA_WIDTH-1:0]       p0_data_out;

    logic                        p1_req;
    logic [1:0]                  p1_write_type;
    logic [2:0]                  p1_read_type;
    logic [ADDRESS_BITWIDTH-1:0] p1_address;
    logic [DATA_WIDTH-1:0]       p1_data_in;
    logic                        p1_gnt;
    logic                        p1_done;
    logic [DATA_WIDTH-1:0]       p1_data_out;

    logic                        ramio_enable;
    logic [1:0]                  ramio_write_type;
    logic [2:0]                  ramio_read_type;
    logic [ADDRESS_BITWIDTH-1:0] ramio_address;
    logic [DATA_WIDTH-1:0]       ramio_data_in;
    logic [DATA_WIDTH-1:0]       ramio_data_out;
    logic                        ramio_data_out_ready;
    logic                        ramio_busy;
    logic                        timeout_err;

    modport slave (
        input  p0_req, p0_write_type, p0_read_type,
        input  p0_address, p0_data_in,
        output p0_gnt, p0_done, p0_data_out,
        input  p1_req, p1_write_type, p1_read_type,
        input  p1_address, p1_data_in,
        output p1_gnt, p1_done, p1_data_out,
        output ramio_enable, ramio_write_type, ramio_read_type,
        output ramio_address, ramio_data_in,
        input  ramio_data_out, ramio_data_out_ready, ramio_busy,
        output timeout_err
    );

    modport master (
        output p0_req, p0_write_type, p0_read_type,
        output p0_address, p0_data_in,
        input  p0_gnt, p0_done, p0_data_out,
        output p1_req, p1_write_type, p1_read_type,
        output p1_address, p1_data_in,
        input  p1_gnt, p1_done, p1_data_out,
        input  ramio_enable, ramio_write_type, ramio_read_type,
        input  ramio_address, ramio_data_in,
        output ramio_data_out, ramio_data_out_ready, ramio_busy,
        input  timeout_err
    );

endinterface

// File: rtl/ramio_rr_picker.sv
// Two-way round-robin winner select. On a tie the port that was
// not granted last wins; a lone requester always wins.
module ramio_rr_picker (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       win_o
);

    assign valid_o = |req_i;
    assign win_o   = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/ramio_arbiter.sv
// Two-port arbiter in front of a single RAMIO command bus: one
// transaction in flight, round-robin grant, sticky timeout abort.
module ramio_arbiter
    import ramio_arbiter_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input logic            clk,
    input logic            rst,
    ramio_arbiter_if.slave bus
);

    localparam int AW = ADDRESS_BITWIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          en_q, en_d;
    logic          terr_q, terr_d;
    logic [1:0]    wt_q, wt_d;
    logic [2:0]    rt_q, rt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] dout0_q, dout0_d;
    logic [DW-1:0] dout1_q, dout1_d;

    logic          pick_v, pick;
    logic [1:0]    sel_wt;
    logic [2:0]    sel_rt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;
    logic [DW-1:0] rdata;
    kind_e         kind;
    logic          grant, complete, tmo;

    ramio_rr_picker u_pick (
        .req_i   ({bus.p1_req, bus.p0_req}),
        .last_i  (last_q),
        .valid_o (pick_v),
        .win_o   (pick)
    );

    assign sel_wt   = pick ? bus.p1_write_type : bus.p0_write_type;
    assign sel_rt   = pick ? bus.p1_read_type  : bus.p0_read_type;
    assign sel_addr = pick ? bus.p1_address    : bus.p0_address;
    assign sel_din  = pick ? bus.p1_data_in    : bus.p0_data_in;

    // The latched command tells what the in-flight transaction is.
    assign kind  = cmd_kind(wt_q, rt_q);
    assign rdata = (kind == K_RD) ? bus.ramio_data_out : '0;
    assign grant = (state_q == S_IDLE) && pick_v && !bus.ramio_busy;

    // Writes ignore busy in the first WAIT cycle: RAMIO may not
    // have seen the enable yet.
    always_comb begin
        complete = 1'b0;
        if (state_q == S_WAIT) begin
            unique case (kind)
                K_NOP:   complete = 1'b1;
                K_WR:    complete = (cnt_q != '0) && !bus.ramio_busy;
                K_RD:    complete = bus.ramio_data_out_ready;
                default: complete = 1'b0;
            endcase
        end
    end

    assign tmo = (state_q == S_WAIT) && !complete
              && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant) state_d = S_WAIT;
            S_WAIT:  if (complete || tmo) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        en_d    = en_q;
        terr_d  = terr_q;
        wt_d    = wt_q;
        rt_d    = rt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q + CW'(1);
        end
        unique case (1'b1)
            grant: begin
                owner_d = pick;
                last_d  = pick;
                gnt_d   = pick ? 2'b10 : 2'b01;
                wt_d    = sel_wt;
                rt_d    = (sel_wt != WT_NONE) ? RT_NONE : sel_rt;
                addr_d  = sel_addr;
                din_d   = sel_din;
                en_d    = (cmd_kind(sel_wt, sel_rt) != K_NOP);
                cnt_d   = '0;
            end
            complete: begin
                en_d   = 1'b0;
                done_d = owner_q ? 2'b10 : 2'b01;
                if (owner_q) dout1_d = rdata;
                else         dout0_d = rdata;
            end
            tmo: begin
                en_d   = 1'b0;
                terr_d = 1'b1;
                done_d = owner_q ? 2'b10 : 2'b01;
                if (owner_q) dout1_d = '0;
                else         dout0_d = '0;
            end
            default: ;
        endcase
    end

    // Reset priority goes to port 0, so port 1 counts as last granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            en_q    <= 1'b0;
            terr_q  <= 1'b0;
            wt_q    <= '0;
            rt_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            terr_q  <= terr_d;
            wt_q    <= wt_d;
            rt_q    <= rt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.p0_gnt           = gnt_q[0];
    assign bus.p1_gnt           = gnt_q[1];
    assign bus.p0_done          = done_q[0];
    assign bus.p1_done          = done_q[1];
    assign bus.p0_data_out      = dout0_q;
    assign bus.p1_data_out      = dout1_q;
    assign bus.ramio_enable     = en_q;
    assign bus.ramio_write_type = wt_q;
    assign bus.ramio_read_type  = rt_q;
    assign bus.ramio_address    = addr_q;
    assign bus.ramio_data_in    = din_q;
    assign bus.timeout_err      = terr_q;

endmodule

// File: doc/ramio_arbiter.md
RAMIO_ARBITER -- requirements
Module: ramio_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDRESS_BITWIDTH, 32, byte address width; DATA_WIDTH, 32, data width; TIMEOUT_CYCLES, 65535, max WAIT cycles before abort.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock; all logic on posedge
  rst  in  1  reset, synchronous, active-high
  pN_req  in  1  port N (N=0,1) requests a transaction; command valid while high
  pN_write_type  in  2  b00 none, b01 byte, b10 half, b11 word
  pN_read_type  in  3  b000 none, [2] sign-extend flag, [1:0] size as write_type
  pN_address  in  ADDRESS_BITWIDTH  byte address
  pN_data_in  in  DATA_WIDTH  write data
  pN_gnt  out  1  one-cycle pulse: port N command captured
  pN_done  out  1  one-cycle pulse: port N transaction finished
  pN_data_out  out  DATA_WIDTH  read data, valid with pN_done
  ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in  out  1/2/3/ADDRESS_BITWIDTH/DATA_WIDTH  shared RAMIO command
  ramio_data_out  in  DATA_WIDTH  RAMIO read data
  ramio_data_out_ready  in  1  RAMIO read data valid
  ramio_busy  in  1  RAMIO busy
  timeout_err  out  1  sticky: a transaction was aborted by timeout

Function
REQ-003 States IDLE, WAIT, DONE; one transaction in flight at a time.
REQ-004 IDLE: grant only when at least one pN_req=1 and ramio_busy=0; else remain IDLE, all ramio_* outputs hold last values except ramio_enable=0.
REQ-005 Round-robin: winner is the requesting port not granted last; a sole requester always wins; after reset port 0 has priority.
REQ-006 Grant cycle t: registered outputs at t+1: winner pN_gnt=1, ramio_enable=1, command fields copied from winner; state WAIT, WAIT counter=0.
REQ-007 Write and read types both nonzero: write wins; ramio_read_type forced b000.
REQ-008 Write and read types both zero: no-op; no ramio_enable; pN_gnt at t+1 and pN_done at t+2 with pN_data_out=0.
REQ-009 WAIT completion: write when ramio_busy=0 sampled at least one cycle after ramio_enable rose; read when ramio_data_out_ready=1 (ramio_busy ignored).
REQ-010 Completion sampled cycle c: at c+1 ramio_enable=0, pN_done=1, pN_data_out = ramio_data_out sampled at c (reads) else 0; state DONE.
REQ-011 DONE lasts exactly one cycle, then IDLE; earliest back-to-back grant is evaluated in IDLE the cycle after DONE.
REQ-012 WAIT counter increments each WAIT cycle; at TIMEOUT_CYCLES: ramio_enable=0, pN_done=1, pN_data_out=0, timeout_err=1 (sticky until rst), state DONE.
REQ-013 pN_gnt, pN_done never high for both ports in the same cycle; non-granted port's outputs stay 0.
REQ-014 Request dropped after grant has no effect on in-flight transaction; request held after pN_done is a new request.
REQ-015 pN_data_out holds its value until next pN_done for that port.

Reset
REQ-016 On rst=1 at posedge: state IDLE, ramio_enable=0, ramio_write_type=0, ramio_read_type=0, ramio_address=0, ramio_data_in=0, pN_gnt=0, pN_done=0, pN_data_out=0, timeout_err=0, priority to port 0, WAIT counter=0.
REQ-017 rst mid-transaction aborts it silently: no pN_done issued.

Structure
REQ-018 Shared package holds write-type and read-type encodings (none/byte/half/word, sign-extend bit) and the arbiter state enum.
REQ-019 One sub-module natural: ramio_rr_picker (combinational 2-way round-robin winner select from requests and last-grant bit).

Verification
REQ-020 Port 0 word write addr 0x10 data 0xDEADBEEF, RAMIO busy 3 cycles -> p0_gnt at t+1, ramio_enable high 4 cycles, p0_done one cycle after busy falls.
REQ-021 Both ports request reads simultaneously, repeated twice -> grant order p0, p1, p0, p1; no overlap of ramio_enable.
REQ-022 Port 1 unsigned half read addr 0x4, RAMIO returns 0x00004120 with data_out_ready -> p1_done with p1_data_out=0x00004120.
REQ-023 TIMEOUT_CYCLES=8, read with data_out_ready never asserted -> p0_done after 8 WAIT cycles, p0_data_out=0, timeout_err=1 persisting.
REQ-024 ramio_busy=1 while p0_req=1 -> no grant until busy=0; rst asserted mid-WAIT -> ramio_enable=0 next cycle, no p0_done.
REQ-025 Command with both types zero -> p0_gnt then p0_done next cycle, ramio_enable never asserted.
